// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// single-cycle data_valid / framing_error pulses.
module uart_rx #(
  parameter int unsigned INPUT_CLOCK = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] in_data,
  output logic       data_valid,
  output logic       framing_error
);

  localparam int unsigned CLKS_PER_BIT = INPUT_CLOCK / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_n;
  logic             sync_q1, rx_s;
  logic [CNT_W-1:0] timer, timer_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       in_data_n;
  logic             data_valid_n, framing_error_n;

  // Next-state, bit timer and output pulse decode
  always_comb begin
    state_n         = state;
    timer_n         = timer + CNT_W'(1);
    bit_idx_n       = bit_idx;
    shift_n         = shift;
    in_data_n       = in_data;
    data_valid_n    = 1'b0;
    framing_error_n = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) state_n = START;
      end

      START: begin
        if (timer == CNT_W'(HALF_BIT - 1)) begin
          timer_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end

      DATA: begin
        if (timer == CNT_W'(CLKS_PER_BIT - 1)) begin
          timer_n          = '0;
          shift_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end

      STOP: begin
        if (timer == CNT_W'(CLKS_PER_BIT - 1)) begin
          timer_n = '0;
          if (rx_s) begin
            state_n      = IDLE;
            in_data_n    = shift;
            data_valid_n = 1'b1;
          end else begin
            state_n         = BREAK;
            framing_error_n = 1'b1;
          end
        end
      end

      // Hold off until the line goes idle so a stuck-low line is not re-parsed
      BREAK: begin
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // State, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sync_q1       <= 1'b1;
      rx_s          <= 1'b1;
      timer         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      in_data       <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      sync_q1       <= uart_in;
      rx_s          <= sync_q1;
      timer         <= timer_n;
      bit_idx       <= bit_idx_n;
      shift         <= shift_n;
      in_data       <= in_data_n;
      data_valid    <= data_valid_n;
      framing_error <= framing_error_n;
    end
  end

endmodule
